rr_arb_4: RTL
=============

Name: rr_arb_4

Overview:
- Four-requester round-robin arbiter that sits directly upstream of the team's 4:1 data multiplexer.
- Its 2-bit select output drives the mux select input, so the granted requester's bit appears on the mux output.
- A grant is held for as long as the winner keeps its request asserted.
- Fairness is rotating priority: the last winner becomes lowest priority.

Parameters:
- HOLD_MAX, 16, maximum consecutive GRANT cycles before forced release; used only when RR_ARB_TIMEOUT_EN is defined; legal range 2..65535.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset; asserts immediately, deasserts synchronously to clk.
- req  input  4  request vector; bit i = requester i wants the mux path.
- grant  output  4  one-hot grant, registered; all zero when no owner.
- sel  output  2  binary index of current or most recent owner; wire straight to the mux select.
- valid  output  1  high while a grant is active; consumer qualifies the mux output with it.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, grant=4'b0000, sel=2'd0, valid=0.
  - Priority pointer ptr=2'd0, hold counter=0.
- States: IDLE and GRANT.
- IDLE:
  - If req==0, stay in IDLE; outputs unchanged (sel keeps its last value so the mux output stays stable).
  - If req!=0, choose the winner w = first set bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - Next cycle: state=GRANT, grant=1<<w, sel=w, valid=1, ptr=w+1 (mod 4, so 3 wraps to 0).
  - Latency from a req rising edge to grant: exactly 1 cycle.
- GRANT:
  - While req[sel]=1, stay in GRANT; grant, sel and valid hold.
  - Requests from other requesters are ignored while a grant is held (no preemption).
  - When req[sel]=0 is sampled: next cycle state=IDLE, grant=0, valid=0, sel unchanged.
- Handover between owners always inserts exactly one IDLE cycle; the minimum grant length is 1 cycle.
- Boundary conditions:
  - A single persistent requester alternates GRANT (N cycles) -> IDLE (1 cycle) -> GRANT only if it deasserts its request; otherwise the grant is held forever (see optional feature).
  - If req drops and a new req rises in the same cycle, release is processed first; the new requester is granted after the IDLE cycle.
  - Reset asserted mid-grant clears everything immediately; no grant survives reset.
- Invariants:
  - grant is always one-hot or zero.
  - valid == |grant.
  - When valid=1, grant == 1<<sel.

Optional Feature:
- Macro: RR_ARB_TIMEOUT_EN.
- Defined:
  - A hold counter clears on entry to GRANT and increments each GRANT cycle.
  - When counter == HOLD_MAX-1 and req[sel] is still 1, the arbiter forces release: next cycle IDLE, grant=0.
  - ptr was already advanced at grant time, so other pending requesters win next.
  - A lone requester is regranted after the single IDLE cycle.
- Undefined:
  - No counter logic is synthesized; grants are held indefinitely; HOLD_MAX is ignored.

Decomposition:
- Package rr_arb_pkg:
  - NUM_REQ=4, SEL_W=2.
  - State typedef {IDLE, GRANT}.
  - Width constant for the hold counter, derived from HOLD_MAX (clog2).
- Sub-module rr_pick4 (combinational):
  - Inputs req[3:0] and ptr[1:0]; outputs any (1 bit) and idx[1:0].
  - Implemented as a rotate, fixed-priority encode, rotate back.
  - Instantiated once in rr_arb_4.

Test Plan:
- Reset: rst_n=0 pulsed mid-grant (owner 2) -> same-cycle async clear: grant=0, sel=0, valid=0; after release, req=4'b0100 -> grant=4'b0100 one cycle later.
- Single request: req=4'b0010 held 5 cycles then dropped -> grant=4'b0010, sel=1 for 5 cycles, then grant=0, sel stays 1, valid=0.
- Rotation: req=4'b1111 with each owner dropping its req after 2 cycles and reasserting it one cycle later -> grant order 0,1,2,3,0, each separated by one IDLE cycle.
- Wrap: ptr=3 (after a grant to requester 2), req=4'b1001 -> requester 3 wins, ptr becomes 0; next arbitration with req=4'b1001 grants requester 0.
- No preemption: owner 1 holding, req rises to 4'b1011 -> grant stays 4'b0010 until req[1] drops, then requester 3 is granted after one IDLE cycle.
- Timeout, RR_ARB_TIMEOUT_EN defined with HOLD_MAX=4: req=4'b0011 held constant -> grant 0 for 4 cycles, IDLE 1 cycle, grant 1 for 4 cycles, repeating. Same stimulus without the macro -> grant 0 held forever.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// ============================================================================
// Module      : rr_arb_pkg
// Description : Shared constants, state type and helpers for rr_arb_4.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package rr_arb_pkg;

    localparam int NUM_REQ      = 4;
    localparam int SEL_W        = 2;
    localparam int HOLD_MAX_DEF = 16;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Counter only has to reach HOLD_MAX-1, so clog2 bits suffice; never below 1.
    function automatic int hold_cnt_w(input int hold_max);
        return (hold_max > 2) ? $clog2(hold_max) : 1;
    endfunction

    localparam int HOLD_CNT_W_DEF = hold_cnt_w(HOLD_MAX_DEF);

endpackage

`default_nettype wire

// File: rtl/rr_pick4.sv
// ============================================================================
// Module      : rr_pick4
// Description : Combinational 4-way rotating-priority picker (rotate,
//               fixed-priority encode, rotate back).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_pick4
    import rr_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               any,
    output logic [SEL_W-1:0]   idx
);

    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]   w_rot;
    logic [SEL_W-1:0]     w_fidx;

    // w_rot[k] is the request of requester (ptr+k) mod 4
    assign w_dbl = {req, req};
    assign w_rot = w_dbl[ptr +: NUM_REQ];

    always_comb begin
        w_fidx = 2'd3;
        if (w_rot[0]) begin
            w_fidx = 2'd0;
        end else if (w_rot[1]) begin
            w_fidx = 2'd1;
        end else if (w_rot[2]) begin
            w_fidx = 2'd2;
        end
    end

    assign any = |req;
    assign idx = w_fidx + ptr;

endmodule

`default_nettype wire

// File: rtl/rr_arb_4.sv
// ============================================================================
// Module      : rr_arb_4
// Description : Four-requester round-robin arbiter with held grants, driving
//               the select of a 4:1 mux. Optional forced release after
//               HOLD_MAX grant cycles when RR_ARB_TIMEOUT_EN is defined.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arb_4
    import rr_arb_pkg::*;
#(
    parameter int HOLD_MAX = HOLD_MAX_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [SEL_W-1:0]   sel,
    output logic               valid
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] w_grant_nxt;
    logic [SEL_W-1:0]   r_sel;
    logic [SEL_W-1:0]   w_sel_nxt;
    logic [SEL_W-1:0]   r_ptr;
    logic [SEL_W-1:0]   w_ptr_nxt;
    logic               w_any;
    logic [SEL_W-1:0]   w_idx;
    logic               w_timeout;

    rr_pick4 u_pick (
        .req (req),
        .ptr (r_ptr),
        .any (w_any),
        .idx (w_idx)
    );

`ifdef RR_ARB_TIMEOUT_EN
    localparam int                c_cnt_w    = hold_cnt_w(HOLD_MAX);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(HOLD_MAX - 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;

    // Held at zero in IDLE so it starts from zero on every grant entry.
    always_comb begin
        w_cnt_nxt = '0;
        if (r_state == GRANT) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    assign w_timeout = (r_cnt == c_cnt_last);
`else
    // No forced release; the HOLD_MAX term is constant-false.
    assign w_timeout = 1'b0 && (HOLD_MAX == 0);
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_sel_nxt   = r_sel;
        w_ptr_nxt   = r_ptr;
        if (r_state == IDLE) begin
            if (w_any) begin
                w_state_nxt = GRANT;
                w_grant_nxt = 4'b0001 << w_idx;
                w_sel_nxt   = w_idx;
                w_ptr_nxt   = w_idx + 2'd1;
            end
        end else begin
            // Release beats any new request; sel stays on the last owner.
            if (!req[r_sel] || w_timeout) begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_sel   <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_sel   <= w_sel_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    assign grant = r_grant;
    assign sel   = r_sel;
    assign valid = (r_state == GRANT);

endmodule

`default_nettype wire
